ssd1963_wr_engine: RTL and testbench
====================================

# ssd1963_wr_engine

Single-clock write sequencer in the `clkB` (panel bus) domain that buffers command/parameter words and drives an 8080-style SSD1963 write bus with programmable setup, strobe and hold times. It sits directly downstream of the flag synchronizer: the synchronizer's one-cycle output pulse is this block's `Kick_clkB` commit input. Its `Done_clkB` pulse is meant to return to the producer domain through a second flag synchronizer.

## Interface
Parameters:
- `DW`, 16: bus and data width.
- `AW`, 3: FIFO address width; depth is 2^AW (8).
- `T_SU`, 1: setup cycles, CS_n/DC/D valid before WR_n falls; must be ≥1.
- `T_WRL`, 2: WR_n low cycles; must be ≥1.
- `T_HLD`, 1: hold cycles, D/DC held after WR_n rises; must be ≥1.

Ports:
- `clkB`  in  1  block clock.
- `rstB_n`  in  1  reset: synchronous, active-low.
- `Kick_clkB`  in  1  one-cycle commit pulse from the flag synchronizer.
- `PushEn`  in  1  write one entry into the FIFO.
- `PushDC`  in  1  DC value for the entry (0 = command, 1 = data).
- `PushData`  in  DW  bus word for the entry.
- `Full`  out  1  FIFO full.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Done_clkB`  out  1  one-cycle pulse at the end of a batch.
- `Overflow`  out  1  sticky flag, set when a push is dropped.
- `LCD_CS_n`, `LCD_WR_n`, `LCD_RD_n`, `LCD_DC`  out  1 each  panel bus controls; `LCD_RD_n` is held at constant 1.
- `LCD_D`  out  DW  panel data bus.

## Operation
- FIFO: 2^AW × (DW+1) bits, holding {DC, data}.
  - Push while `Full` is dropped and sets `Overflow`.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
- States: IDLE, SETUP, STROBE, HOLD, GAP (GAP is absent when the macro below is defined).
- IDLE:
  - On `Kick_clkB` with the FIFO non-empty: pop the head, register DC/D, assert CS_n low, and go to SETUP.
  - On `Kick_clkB` with the FIFO empty: pulse `Done_clkB` on the next cycle; the bus does not move.
- SETUP: hold WR_n=1 for T_SU cycles, then go to STROBE.
- STROBE: hold WR_n=0 for T_WRL cycles, then go to HOLD.
- HOLD: hold WR_n=1 with D/DC held for T_HLD cycles. Then:
  - If the FIFO is non-empty: go to GAP, or pop and go directly to SETUP when `SSD_CS_BURST_EN` is defined.
  - If the FIFO is empty: go to IDLE, set CS_n=1, pulse `Done_clkB`, and clear `Busy`.
- GAP: one cycle with CS_n=1 and WR_n=1, then pop and go to SETUP.
- A batch drains until the FIFO is empty, so words pushed mid-batch are sent in the same batch.
- A `Kick_clkB` arriving while `Busy` sets a one-deep pending bit. On return to IDLE with pending set and the FIFO non-empty, a new batch starts the next cycle. Further kicks while pending are merged into that one bit.
- One shared down-counter times all phases; it is loaded with the phase length minus 1.
- All bus outputs are registered, with no combinational paths from inputs.
- Reset values:
  - CS_n=1, WR_n=1, RD_n=1, DC=0, D=0.
  - Busy=0, Done_clkB=0, Full=0, Overflow=0.
  - FIFO empty, pending=0, state IDLE.
- Reset asserted mid-word: the bus goes idle on the next edge, the FIFO contents are discarded, and no Done pulse is produced.

## Timing
- Kick at edge n (IDLE, non-empty): at n+1, CS_n=0 and D/DC are valid.
- WR_n falls at n+1+T_SU and rises at n+1+T_SU+T_WRL.
- Word period with defaults: 4 cycles when `SSD_CS_BURST_EN` is defined, otherwise 5 (T_SU+T_WRL+T_HLD, plus GAP).
- Done_clkB is high for exactly one cycle, at the same edge CS_n returns to 1.
- `Full` is registered and updates the cycle after the push or pop that changes it.

## Configuration
- `SSD_CS_BURST_EN` defined:
  - CS_n stays low across all words of a batch; there is no GAP state.
  - The next word's SETUP follows HOLD directly.
- Undefined: CS_n deasserts for one GAP cycle between consecutive words.

## Test plan
- Reset, then push 3 words {0,0x2C},{1,0x1234},{1,0xABCD} and kick → 3 WR_n low pulses of 2 cycles each, with D/DC matching each word; one Done pulse; Busy low after.
- Kick with the FIFO empty → Done high for exactly one cycle; CS_n and WR_n never toggle.
- Push 9 words without kicking → Full after the 8th; the 9th is dropped; Overflow=1 and stays 1 until reset; the drain emits exactly 8 words.
- Kick during a batch, then push 2 more words after the first drain completes but before IDLE → the pending kick triggers a second batch of 2 words and 2 Done pulses in total.
- Assert rstB_n=0 during STROBE → next edge: WR_n=1, CS_n=1, FIFO empty, no Done pulse; a later kick produces no bus activity.
- With and without `SSD_CS_BURST_EN`, 4 words → total bus time of 16 and 19 cycles respectively; CS_n gap pulses counted as 0 and 3.

Source files
------------

// File: rtl/ssd1963_wr_engine.sv
// ssd1963_wr_engine: buffered 8080-style SSD1963 write sequencer; define SSD_CS_BURST_EN to keep CS_n low across a batch
module ssd1963_wr_engine #(
   parameter int DW    = 16,
   parameter int AW    = 3,
   parameter int T_SU  = 1,
   parameter int T_WRL = 2,
   parameter int T_HLD = 1
) (
   input  logic          clkB,
   input  logic          rstB_n,
   input  logic          Kick_clkB,
   input  logic          PushEn,
   input  logic          PushDC,
   input  logic [DW-1:0] PushData,
   output logic          Full,
   output logic          Busy,
   output logic          Done_clkB,
   output logic          Overflow,
   output logic          LCD_CS_n,
   output logic          LCD_WR_n,
   output logic          LCD_RD_n,
   output logic          LCD_DC,
   output logic [DW-1:0] LCD_D
);
   localparam int DEPTH = 1 << AW;
   localparam int CW = 8;
`ifdef SSD_CS_BURST_EN
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`else
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;
`endif
   state_t        state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic          pop, doneNext, pending, pushOk, empty;
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count, countNext;
   logic [DW:0]   mem [DEPTH];

   assign empty     = count == '0;
   assign pushOk    = PushEn && (!Full || pop);
   assign countNext = count + (AW+1)'(pushOk) - (AW+1)'(pop);
   assign Busy      = state != IDLE;
   assign LCD_RD_n  = 1'b1;

   // Next state: each phase runs until the shared counter hits zero; pops happen on entry to SETUP
   always_comb begin
      stateNext = state;
      cntNext   = cnt - 1'b1;
      pop       = 1'b0;
      doneNext  = 1'b0;
      case (state)
         IDLE:
            if ((Kick_clkB || pending) && !empty) begin
               stateNext = SETUP;
               cntNext   = CW'(T_SU - 1);
               pop       = 1'b1;
            end else
               doneNext = Kick_clkB;
         SETUP:
            if (cnt == '0) begin
               stateNext = STROBE;
               cntNext   = CW'(T_WRL - 1);
            end
         STROBE:
            if (cnt == '0) begin
               stateNext = HOLD;
               cntNext   = CW'(T_HLD - 1);
            end
         HOLD:
            if (cnt == '0) begin
               if (empty) begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
               end else begin
`ifdef SSD_CS_BURST_EN
                  stateNext = SETUP;
                  cntNext   = CW'(T_SU - 1);
                  pop       = 1'b1;
`else
                  stateNext = GAP;
`endif
               end
            end
`ifndef SSD_CS_BURST_EN
         GAP: begin
            stateNext = SETUP;
            cntNext   = CW'(T_SU - 1);
            pop       = 1'b1;
         end
`endif
         default: stateNext = IDLE;
      endcase
   end

   // State, timer, pending kick and FIFO bookkeeping
   always_ff @(posedge clkB) begin
      if (!rstB_n) begin
         state    <= IDLE;
         cnt      <= '0;
         pending  <= 1'b0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         Full     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         pending  <= (state != IDLE) && (pending || Kick_clkB);
         wrPtr    <= wrPtr + AW'(pushOk);
         rdPtr    <= rdPtr + AW'(pop);
         count    <= countNext;
         Full     <= countNext == (AW+1)'(DEPTH);
         Overflow <= Overflow || (PushEn && !pushOk);
      end
   end

   // FIFO storage; stale entries are ignored once the pointers reset
   always_ff @(posedge clkB) begin
      if (pushOk) mem[wrPtr] <= {PushDC, PushData};
   end

   // Registered bus outputs decoded from the upcoming state
   always_ff @(posedge clkB) begin
      if (!rstB_n) begin
         LCD_CS_n  <= 1'b1;
         LCD_WR_n  <= 1'b1;
         LCD_DC    <= 1'b0;
         LCD_D     <= '0;
         Done_clkB <= 1'b0;
      end else begin
         LCD_CS_n  <= !(stateNext inside {SETUP, STROBE, HOLD});
         LCD_WR_n  <= stateNext != STROBE;
         Done_clkB <= doneNext;
         if (pop) {LCD_DC, LCD_D} <= mem[rdPtr];
      end
   end
endmodule

// File: tb/tb_ssd1963_wr_engine.sv
// tb_ssd1963_wr_engine: randomized scoreboard bench for ssd1963_wr_engine (honours SSD_CS_BURST_EN)
module tb_ssd1963_wr_engine;
   localparam int DW = 16, AW = 3, T_SU = 1, T_WRL = 2, T_HLD = 1;
`ifdef SSD_CS_BURST_EN
   localparam int SPAN4 = 4 * (T_SU + T_WRL + T_HLD), GAPS4 = 0;
`else
   localparam int SPAN4 = 4 * (T_SU + T_WRL + T_HLD) + 3, GAPS4 = 3;
`endif
   logic clkB = 0, rstB_n = 0, Kick_clkB = 0, PushEn = 0, PushDC = 0;
   logic [DW-1:0] PushData = '0;
   logic Full, Busy, Done_clkB, Overflow, LCD_CS_n, LCD_WR_n, LCD_RD_n, LCD_DC;
   logic [DW-1:0] LCD_D;
   int checks = 0, failures = 0, wrFalls = 0, csFalls = 0, doneCount = 0;
   logic [DW:0] expQ[$];
   logic ovfExp = 0;
   logic prevWr = 1, prevCs = 1, prevDone = 0, firstWord = 0;
   int hiCnt = 0, loCnt = 0;
   logic [DW:0] held = '0, expWord;

   ssd1963_wr_engine #(.DW(DW), .AW(AW), .T_SU(T_SU), .T_WRL(T_WRL), .T_HLD(T_HLD)) dut (
      .clkB(clkB), .rstB_n(rstB_n), .Kick_clkB(Kick_clkB), .PushEn(PushEn), .PushDC(PushDC),
      .PushData(PushData), .Full(Full), .Busy(Busy), .Done_clkB(Done_clkB), .Overflow(Overflow),
      .LCD_CS_n(LCD_CS_n), .LCD_WR_n(LCD_WR_n), .LCD_RD_n(LCD_RD_n), .LCD_DC(LCD_DC), .LCD_D(LCD_D)
   );

   always #5 clkB = ~clkB;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic dc, input logic [DW-1:0] d);
      PushEn = 1; PushDC = dc; PushData = d;
      if (expQ.size() < (1 << AW)) expQ.push_back({dc, d});
      else ovfExp = 1;
      @(negedge clkB);
      PushEn = 0;
   endtask

   task automatic kick();
      Kick_clkB = 1;
      @(negedge clkB);
      Kick_clkB = 0;
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clkB);
      while (Busy && n < 300) begin
         @(negedge clkB);
         n++;
      end
      chk("idle_reached", Busy, 0);
      repeat (2) @(negedge clkB);
   endtask

   // Monitor: pops the scoreboard on every WR_n fall and checks strobe timing and Done shape
   always @(negedge clkB) begin
      if (!rstB_n) begin
         prevWr = 1; prevCs = 1; prevDone = 0; hiCnt = 0; loCnt = 0; firstWord = 0;
      end else begin
         if (prevCs && !LCD_CS_n) begin
            csFalls++;
            firstWord = 1;
         end
         if (prevWr && !LCD_WR_n) begin
            wrFalls++;
            chk("setup_cycles", hiCnt, firstWord ? T_SU : T_HLD + T_SU);
            chk("cs_during_wr", LCD_CS_n, 0);
            firstWord = 0;
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word actual=%0h required=none", {LCD_DC, LCD_D});
            end else begin
               expWord = expQ.pop_front();
               chk("word", {LCD_DC, LCD_D}, expWord);
            end
            held = {LCD_DC, LCD_D};
            loCnt = 0;
         end
         if (!LCD_WR_n) loCnt++;
         if (!prevWr && LCD_WR_n) begin
            chk("wr_low_cycles", loCnt, T_WRL);
            chk("hold_word", {LCD_DC, LCD_D}, held);
         end
         hiCnt = (!LCD_CS_n && LCD_WR_n) ? hiCnt + 1 : 0;
         if (Done_clkB) begin
            doneCount++;
            chk("done_width", prevDone, 0);
            chk("done_cs_high", LCD_CS_n, 1);
         end
         prevWr = LCD_WR_n; prevCs = LCD_CS_n; prevDone = Done_clkB;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0, c0, n, rises, span, gaps;
      logic pw, started, doneSeen;
      repeat (3) @(negedge clkB);
      chk("rst_cs", LCD_CS_n, 1);
      chk("rst_wr", LCD_WR_n, 1);
      chk("rst_rd", LCD_RD_n, 1);
      chk("rst_dc_d", {LCD_DC, LCD_D}, 0);
      chk("rst_flags", {Busy, Done_clkB, Full, Overflow}, 0);
      rstB_n = 1;
      @(negedge clkB);

      d0 = doneCount; w0 = wrFalls;
      push(0, 16'h002C); push(1, 16'h1234); push(1, 16'hABCD);
      kick();
      waitIdle();
      chk("batch3_words", wrFalls - w0, 3);
      chk("batch3_done", doneCount - d0, 1);
      chk("batch3_busy", Busy, 0);
      chk("batch3_drained", expQ.size(), 0);

      d0 = doneCount; w0 = wrFalls; c0 = csFalls;
      kick();
      chk("empty_kick_busy", Busy, 0);
      repeat (3) @(negedge clkB);
      chk("empty_kick_done", doneCount - d0, 1);
      chk("empty_kick_wr", wrFalls - w0, 0);
      chk("empty_kick_cs", csFalls - c0, 0);

      d0 = doneCount; w0 = wrFalls;
      for (int i = 0; i < 9; i++) begin
         push(1'($urandom_range(0, 1)), 16'($urandom));
         if (i == 6) chk("full_after7", Full, 0);
         if (i == 7) chk("full_after8", Full, 1);
      end
      chk("overflow_set", Overflow, ovfExp);
      kick();
      waitIdle();
      chk("overflow_drain_words", wrFalls - w0, 8);
      chk("overflow_sticky", Overflow, 1);
      chk("full_cleared", Full, 0);
      chk("overflow_drained", expQ.size(), 0);

      d0 = doneCount; w0 = wrFalls;
      for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), 16'($urandom));
      kick();
      kick();
      pw = LCD_WR_n; rises = 0; n = 0;
      while (rises < 3 && n < 100) begin
         @(negedge clkB);
         if (!pw && LCD_WR_n) rises++;
         pw = LCD_WR_n;
         n++;
      end
      chk("pending_third_rise", rises, 3);
      push(1'($urandom_range(0, 1)), 16'($urandom));
      push(1'($urandom_range(0, 1)), 16'($urandom));
      waitIdle();
      chk("pending_words", wrFalls - w0, 5);
      chk("pending_done", doneCount - d0, 2);

      for (int b = 0; b < 3; b++) begin
         d0 = doneCount; w0 = wrFalls;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) push(1'($urandom_range(0, 1)), 16'($urandom));
         kick();
         waitIdle();
         chk("rand_words", wrFalls - w0, n);
         chk("rand_done", doneCount - d0, 1);
      end

      for (int i = 0; i < 4; i++) push(1'($urandom_range(0, 1)), 16'($urandom));
      kick();
      span = 0; gaps = 0; started = 0; doneSeen = 0;
      for (int i = 0; i < 200 && !doneSeen; i++) begin
         if (Done_clkB) doneSeen = 1;
         else begin
            if (!LCD_CS_n) started = 1;
            if (started) begin
               span++;
               if (LCD_CS_n) gaps++;
            end
            @(negedge clkB);
         end
      end
      chk("span4_done_seen", doneSeen, 1);
      chk("span4_cycles", span, SPAN4);
      chk("span4_gaps", gaps, GAPS4);
      repeat (2) @(negedge clkB);

      d0 = doneCount; w0 = wrFalls; c0 = csFalls;
      push(0, 16'h00AA); push(1, 16'h5555);
      kick();
      n = 0;
      while (LCD_WR_n && n < 20) begin
         @(negedge clkB);
         n++;
      end
      chk("reach_strobe", LCD_WR_n, 0);
      rstB_n = 0;
      expQ.delete();
      ovfExp = 0;
      @(negedge clkB);
      chk("midrst_wr", LCD_WR_n, 1);
      chk("midrst_cs", LCD_CS_n, 1);
      chk("midrst_flags", {Busy, Done_clkB, Full, Overflow}, {3'b000, ovfExp});
      @(negedge clkB);
      rstB_n = 1;
      @(negedge clkB);
      w0 = wrFalls; c0 = csFalls;
      kick();
      repeat (4) @(negedge clkB);
      chk("postrst_wr", wrFalls - w0, 0);
      chk("postrst_cs", csFalls - c0, 0);
      chk("postrst_done", doneCount - d0, 1);
      chk("postrst_busy", Busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
